// File: rtl/conv_mem_responder.sv
// conv_mem_responder
//
// Memory-side partner of the convolution engine. Holds the 64x64 input
// image, the layer-0 bank and the layer-1 bank. Runs the ready/busy start
// handshake, serves combinational image and layer reads, counts accepted
// layer writes and raises a one-cycle completion pulse.
//
// Optional feature: define CONV_MEM_CHK_EN to build the sticky protocol
// checker behind `err`. Without it `err` is tied to zero.
//
// Handshake: `start` is accepted only in IDLE; `ready` goes high the cycle
// after acceptance and drops the cycle after `busy`=1 is sampled; once
// `busy`=0 is sampled in RUN, `done` pulses for one cycle two cycles later.
//
// Ports:
//   clk, reset (sync, active-low)
//   start                         host arm pulse
//   img_we/img_addr/img_wdata     image load port (IDLE only)
//   ready, busy                   engine start handshake
//   iaddr -> idata                combinational image fetch
//   cwr/caddr_wr/cdata_wr         layer write port
//   crd/caddr_rd -> cdata_rd      combinational layer read port
//   csel                          bank select: 001 = L0, 011 = L1
//   dbg_sel/dbg_addr -> dbg_data  combinational debug read
//   done                          one-cycle completion pulse
//   l0_cnt, l1_cnt                saturating write counters
//   err                           sticky protocol flags
module conv_mem_responder #(
  parameter int DW        = 20,
  parameter int IMG_DEPTH = 4096,
  parameter int L0_DEPTH  = 4096,
  parameter int L1_DEPTH  = 1024
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          img_we,
  input  logic [11:0]   img_addr,
  input  logic [DW-1:0] img_wdata,
  output logic          ready,
  input  logic          busy,
  input  logic [11:0]   iaddr,
  output logic [DW-1:0] idata,
  input  logic          cwr,
  input  logic [11:0]   caddr_wr,
  input  logic [DW-1:0] cdata_wr,
  input  logic          crd,
  input  logic [11:0]   caddr_rd,
  output logic [DW-1:0] cdata_rd,
  input  logic [2:0]    csel,
  input  logic [2:0]    dbg_sel,
  input  logic [11:0]   dbg_addr,
  output logic [DW-1:0] dbg_data,
  output logic          done,
  output logic [12:0]   l0_cnt,
  output logic [10:0]   l1_cnt,
  output logic [3:0]    err
);

  localparam int         L1_AW  = $clog2(L1_DEPTH);
  localparam logic [2:0] SEL_L0 = 3'b001;
  localparam logic [2:0] SEL_L1 = 3'b011;
  localparam logic [12:0] L0_MAX = 13'(L0_DEPTH);
  localparam logic [12:0] L1_LIM = 13'(L1_DEPTH);
  localparam logic [10:0] L1_MAX = 11'(L1_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_READY, S_RUN, S_DONE} state_t;
  state_t state;

  logic [DW-1:0] img_mem [IMG_DEPTH];
  logic [DW-1:0] l0_mem  [L0_DEPTH];
  logic [DW-1:0] l1_mem  [L1_DEPTH];

  logic accept_start;
  logic l0_wr;
  logic l1_wr;

  function automatic logic l0_in(input logic [11:0] a);
    return {1'b0, a} < L0_MAX;
  endfunction

  function automatic logic l1_in(input logic [11:0] a);
    return {1'b0, a} < L1_LIM;
  endfunction

  // Shared bank decode for the layer and debug read ports; anything that
  // does not name a valid bank/address reads as zero.
  function automatic logic [DW-1:0] bank_rd(input logic [2:0] sel, input logic [11:0] a);
    logic [DW-1:0] r;
    r = '0;
    if (sel == SEL_L0 && l0_in(a)) r = l0_mem[a];
    else if (sel == SEL_L1 && l1_in(a)) r = l1_mem[a[L1_AW-1:0]];
    return r;
  endfunction

  assign accept_start = (state == S_IDLE) && start;
  assign l0_wr        = cwr && (csel == SEL_L0) && l0_in(caddr_wr);
  assign l1_wr        = cwr && (csel == SEL_L1) && l1_in(caddr_wr);

  // Arrays are never cleared; writes are simply held off while reset is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (img_we && state == S_IDLE) img_mem[img_addr] <= img_wdata;
      if (l0_wr) l0_mem[caddr_wr] <= cdata_wr;
      if (l1_wr) l1_mem[caddr_wr[L1_AW-1:0]] <= cdata_wr;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= S_IDLE;
      ready  <= 1'b0;
      done   <= 1'b0;
      l0_cnt <= '0;
      l1_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          state <= S_READY;
          ready <= 1'b1;
        end
        S_READY: if (busy) begin
          state <= S_RUN;
          ready <= 1'b0;
        end
        S_RUN: if (!busy) state <= S_DONE;
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase

      if (accept_start) begin
        l0_cnt <= '0;
        l1_cnt <= '0;
      end else begin
        if (l0_wr && l0_cnt != L0_MAX) l0_cnt <= l0_cnt + 13'd1;
        if (l1_wr && l1_cnt != L1_MAX) l1_cnt <= l1_cnt + 11'd1;
      end
    end
  end

`ifdef CONV_MEM_CHK_EN
  logic [3:0] err_q;
  logic [3:0] err_set;

  always_comb begin
    err_set    = '0;
    err_set[0] = cwr && crd;
    err_set[1] = cwr && (csel == SEL_L1) && !l1_in(caddr_wr);
    err_set[2] = (cwr || crd) && (csel != SEL_L0) && (csel != SEL_L1);
    err_set[3] = busy && (state == S_IDLE);
  end

  // An accepted start clears the flags even if a violation coincides.
  always_ff @(posedge clk) begin
    if (!reset)            err_q <= '0;
    else if (accept_start) err_q <= '0;
    else                   err_q <= err_q | err_set;
  end

  assign err = err_q;
`else
  assign err = 4'b0000;
`endif

  assign idata    = img_mem[iaddr];
  assign cdata_rd = crd ? bank_rd(csel, caddr_rd) : '0;
  assign dbg_data = bank_rd(dbg_sel, dbg_addr);

endmodule

// File: tb/tb_conv_mem_responder.sv
// Bench for conv_mem_responder: handshake timing, image path, L0 fill and
// saturation, L1 bound, read/write collision, invalid select, reset mid-RUN.
module tb_conv_mem_responder;
  localparam int DW = 20;

`ifdef CONV_MEM_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          img_we = 1'b0;
  logic [11:0]   img_addr = '0;
  logic [DW-1:0] img_wdata = '0;
  logic          ready;
  logic          busy = 1'b0;
  logic [11:0]   iaddr = '0;
  logic [DW-1:0] idata;
  logic          cwr = 1'b0;
  logic [11:0]   caddr_wr = '0;
  logic [DW-1:0] cdata_wr = '0;
  logic          crd = 1'b0;
  logic [11:0]   caddr_rd = '0;
  logic [DW-1:0] cdata_rd;
  logic [2:0]    csel = 3'b000;
  logic [2:0]    dbg_sel = 3'b001;
  logic [11:0]   dbg_addr = '0;
  logic [DW-1:0] dbg_data;
  logic          done;
  logic [12:0]   l0_cnt;
  logic [10:0]   l1_cnt;
  logic [3:0]    err;

  conv_mem_responder dut (
    .clk(clk), .reset(reset), .start(start),
    .img_we(img_we), .img_addr(img_addr), .img_wdata(img_wdata),
    .ready(ready), .busy(busy), .iaddr(iaddr), .idata(idata),
    .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
    .csel(csel), .dbg_sel(dbg_sel), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .done(done), .l0_cnt(l0_cnt), .l1_cnt(l1_cnt), .err(err)
  );

  // scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic sb_chk(input string name, input logic [DW-1:0] act);
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: got %0h expected <empty queue>", name, act);
    end else begin
      chk(name, 32'(act), 32'(exp_q.pop_front()));
    end
  endtask

  // models
  function automatic logic [DW-1:0] img_val(input int k);
    return DW'(k) ^ 20'h5A5A5;
  endfunction

  function automatic logic [DW-1:0] l0_val(input int k);
    return DW'(k * 37 + 11) ^ 20'hC3A5F;
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lwrite(input logic [2:0] sel, input logic [11:0] a, input logic [DW-1:0] d);
    csel = sel; caddr_wr = a; cdata_wr = d; cwr = 1'b1;
    step();
    cwr = 1'b0;
  endtask

  typedef struct {
    logic          rd;
    logic [2:0]    sel;
    logic [11:0]   addr;
    logic [2:0]    dsel;
    logic [11:0]   daddr;
    logic [DW-1:0] exp_rd;
    logic [DW-1:0] exp_dbg;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b1, 3'b001, 12'd10,   3'b001, 12'd20,   l0_val(10),  l0_val(20)};
    vecs[1] = '{1'b0, 3'b001, 12'd10,   3'b011, 12'd1023, 20'h0,       20'hABCDE};
    vecs[2] = '{1'b1, 3'b011, 12'd1023, 3'b011, 12'd1024, 20'hABCDE,   20'h0};
    vecs[3] = '{1'b1, 3'b010, 12'd10,   3'b010, 12'd10,   20'h0,       20'h0};
    vecs[4] = '{1'b1, 3'b000, 12'd10,   3'b111, 12'd10,   20'h0,       20'h0};
    vecs[5] = '{1'b1, 3'b011, 12'd4095, 3'b001, 12'd4095, 20'h0,       l0_val(4095)};

    // reset low for two cycles
    step();
    step();
    chk("rst_ready", 32'(ready), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_l0_cnt", 32'(l0_cnt), 0);
    chk("rst_l1_cnt", 32'(l1_cnt), 0);
    chk("rst_err", 32'(err), 0);
    reset = 1'b1;

    // image load in IDLE
    for (int k = 0; k < 4096; k++) begin
      img_we = 1'b1; img_addr = 12'(k); img_wdata = img_val(k);
      step();
    end
    img_we = 1'b0;

    // handshake
    start = 1'b1;
    #1 chk("ready_before_start", 32'(ready), 0);
    step();
    start = 1'b0;
    chk("ready_rise", 32'(ready), 1);
    step();
    chk("ready_hold1", 32'(ready), 1);
    step();
    chk("ready_hold2", 32'(ready), 1);
    busy = 1'b1;
    step();
    chk("ready_fall", 32'(ready), 0);
    img_we = 1'b1; img_addr = 12'd7; img_wdata = 20'hFFFFF;
    step();
    img_we = 1'b0;
    for (int c = 0; c < 99; c++) begin
      chk("run_quiet", 32'({ready, done}), 0);
      step();
    end
    busy = 1'b0;
    step();
    chk("done_wait", 32'(done), 0);
    step();
    chk("done_pulse", 32'(done), 1);
    step();
    chk("done_clear", 32'(done), 0);

    // image sweep (includes address 7 written during RUN)
    for (int k = 0; k < 4096; k++) begin
      iaddr = 12'(k);
      exp_q.push_back(img_val(k));
      #1 sb_chk("img_rd", idata);
      step();
    end

    // L0 fill, count, saturation
    for (int k = 0; k < 4096; k++) lwrite(3'b001, 12'(k), l0_val(k));
    chk("l0_cnt_full", 32'(l0_cnt), 4096);
    lwrite(3'b001, 12'd0, l0_val(0));
    chk("l0_cnt_sat", 32'(l0_cnt), 4096);

    csel = 3'b001; crd = 1'b1; dbg_sel = 3'b001;
    for (int k = 0; k < 4096; k++) begin
      caddr_rd = 12'(k); dbg_addr = 12'(4095 - k);
      exp_q.push_back(l0_val(k));
      exp_q.push_back(l0_val(4095 - k));
      #1;
      sb_chk("l0_rd", cdata_rd);
      sb_chk("l0_dbg", dbg_data);
      step();
    end
    crd = 1'b0;

    // L1 bound
    lwrite(3'b011, 12'd1023, 20'hABCDE);
    lwrite(3'b011, 12'd1024, 20'h12345);
    chk("l1_cnt_one", 32'(l1_cnt), 1);
    chk("l1_err", 32'(err), CHK ? 32'h2 : 32'h0);
    csel = 3'b011; crd = 1'b1; caddr_rd = 12'd1023;
    #1 chk("l1_rd_1023", 32'(cdata_rd), 32'hABCDE);
    caddr_rd = 12'd1024;
    #1 chk("l1_rd_1024", 32'(cdata_rd), 0);
    crd = 1'b0;
    step();

    // read decode table
    for (int i = 0; i < 6; i++) begin
      crd = vecs[i].rd; csel = vecs[i].sel; caddr_rd = vecs[i].addr;
      dbg_sel = vecs[i].dsel; dbg_addr = vecs[i].daddr;
      #1;
      chk($sformatf("vec%0d_rd", i), 32'(cdata_rd), 32'(vecs[i].exp_rd));
      chk($sformatf("vec%0d_dbg", i), 32'(dbg_data), 32'(vecs[i].exp_dbg));
      step();
    end
    crd = 1'b0;

    // collision: same-cycle read returns old data
    lwrite(3'b001, 12'd5, 20'd3);
    csel = 3'b001; caddr_wr = 12'd5; cdata_wr = 20'd9; cwr = 1'b1;
    crd = 1'b1; caddr_rd = 12'd5;
    #1 chk("collide_old", 32'(cdata_rd), 3);
    step();
    cwr = 1'b0;
    #1 chk("collide_new", 32'(cdata_rd), 9);
    crd = 1'b0;

    // invalid select write is dropped
    lwrite(3'b010, 12'd5, 20'h77777);
    dbg_sel = 3'b001; dbg_addr = 12'd5;
    #1 chk("badsel_drop", 32'(dbg_data), 9);
    chk("badsel_l0_cnt", 32'(l0_cnt), 4096);
    chk("badsel_l1_cnt", 32'(l1_cnt), 1);
    chk("err_flags", 32'(err), CHK ? 32'h7 : 32'h0);
    busy = 1'b1;
    step();
    busy = 1'b0;
    chk("err_busy_idle", 32'(err), CHK ? 32'hF : 32'h0);

    // accepted start clears counters and flags; repeat start ignored
    start = 1'b1;
    step();
    chk("start_ready", 32'(ready), 1);
    chk("start_err_clr", 32'(err), 0);
    chk("start_l0_clr", 32'(l0_cnt), 0);
    chk("start_l1_clr", 32'(l1_cnt), 0);
    step();
    start = 1'b0;
    chk("start_in_ready", 32'(ready), 1);
    busy = 1'b1;
    step();
    chk("run_entered", 32'(ready), 0);
    lwrite(3'b001, 12'd100, 20'h13579);
    chk("run_l0_cnt", 32'(l0_cnt), 1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_in_run", 32'(l0_cnt), 1);

    // reset mid-RUN
    reset = 1'b0;
    step();
    chk("mid_rst_ready", 32'(ready), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_l0", 32'(l0_cnt), 0);
    chk("mid_rst_err", 32'(err), 0);
    reset = 1'b1;
    busy = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("mid_rst_no_done", 32'({ready, done}), 0);
    end
    dbg_sel = 3'b001; dbg_addr = 12'd100;
    #1 chk("keep_l0_100", 32'(dbg_data), 32'h13579);
    dbg_addr = 12'd10;
    #1 chk("keep_l0_10", 32'(dbg_data), 32'(l0_val(10)));
    dbg_sel = 3'b011; dbg_addr = 12'd1023;
    #1 chk("keep_l1_1023", 32'(dbg_data), 32'hABCDE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/conv_mem_responder.md
# conv_mem_responder

Responder side of the CONV layer-memory protocol: the block that sits opposite the convolution engine and answers its `ready`/`busy` start handshake, image fetch port (`iaddr`/`idata`) and layer-memory ports (`cwr`/`crd`/`csel`/`caddr_*`/`cdata_*`). It holds the 64x64 input image, the layer-0 bank (4096 words) and the layer-1 bank (1024 words). It counts the engine's writes, signals completion, and exposes a debug read port for result checking. It replaces the behavioural testbench memories so that the engine can be verified and integrated against synthesizable RTL.

## Interface
- `DW`, 20, data width (Q16.4 fixed point, raw bits).
- `IMG_DEPTH`, 4096, image words.
- `L0_DEPTH`, 4096, layer-0 bank words (csel 3'b001).
- `L1_DEPTH`, 1024, layer-1 bank words (csel 3'b011).

Ports:
- `clk`  in  1  sole clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-low: sampled 0 at rising edge resets.
- `start`  in  1  host pulse that arms the handshake.
- `img_we`  in  1  image load strobe (honoured in IDLE only).
- `img_addr`  in  12  image load address.
- `img_wdata`  in  DW  image load data.
- `ready`  out  1  image available to engine.
- `busy`  in  1  engine busy.
- `iaddr`  in  12  image fetch address.
- `idata`  out  DW  image word at `iaddr`.
- `cwr`  in  1  layer write enable.
- `caddr_wr`  in  12  layer write address.
- `cdata_wr`  in  DW  layer write data.
- `crd`  in  1  layer read enable.
- `caddr_rd`  in  12  layer read address.
- `cdata_rd`  out  DW  layer read data.
- `csel`  in  3  bank select: 3'b001 L0, 3'b011 L1, others invalid.
- `dbg_sel`  in  3  debug bank select (same encoding).
- `dbg_addr`  in  12  debug address.
- `dbg_data`  out  DW  debug read data.
- `done`  out  1  one-cycle completion pulse.
- `l0_cnt`  out  13  L0 write count, saturating at 4096.
- `l1_cnt`  out  11  L1 write count, saturating at 1024.
- `err`  out  4  sticky protocol flags (see Configuration).

## Operation
- FSM states are IDLE, READY, RUN and DONE.
  - IDLE: `ready`=0. `img_we` writes `img_wdata` to image[`img_addr`]. On `start`=1, go to READY and clear `l0_cnt`, `l1_cnt` and `err`.
  - READY: `ready`=1. When `busy`=1 is sampled, go to RUN.
  - RUN: `ready`=0. Serve image and layer ports. When `busy`=0 is sampled, go to DONE.
  - DONE: `done`=1 for exactly one cycle, then go to IDLE.
- Image read: `idata` = image[`iaddr`] combinationally, in every state. Out-of-range is impossible because addresses are 12 bits.
- Layer write:
  - At a rising edge with `cwr`=1 and `csel`=001, write L0[`caddr_wr`] and increment `l0_cnt`.
  - With `csel`=011 and `caddr_wr` < `L1_DEPTH`, write L1[`caddr_wr`] and increment `l1_cnt`.
  - Any other combination is dropped with no state change.
  - Writes are accepted in any state, not only RUN.
- Layer read: `cdata_rd` = bank[`caddr_rd`] combinationally when `crd`=1 and `csel` is valid. Otherwise `cdata_rd` = 0. An L1 address ≥ `L1_DEPTH` returns 0.
- Debug read: `dbg_data` = bank[`dbg_addr`] combinationally, same decode as the layer read, with no enable.
- Counters saturate and never wrap.
- `start` in a state other than IDLE is ignored.
- `img_we` outside IDLE is ignored.

## Timing
- Reset values: `ready`=0, `done`=0, `l0_cnt`=0, `l1_cnt`=0, `err`=0, FSM=IDLE. `idata`, `cdata_rd` and `dbg_data` are combinational.
- Memory arrays are not cleared by reset. Reset mid-RUN aborts to IDLE with no `done` pulse.
- Handshake latency:
  - `ready` rises in the cycle after `start` is sampled.
  - `ready` falls in the cycle after `busy`=1 is sampled.
  - `done` pulses two cycles after `busy`=0 is sampled in RUN.
- Write-to-read: a word written at edge N is visible on `cdata_rd`/`dbg_data` after edge N. A same-cycle read of the same address returns the old data.
- Simultaneous `cwr` and `crd` to the same bank: the write proceeds and the read returns the old data.

## Configuration
- Macro `CONV_MEM_CHK_EN`. When defined, `err` bits are sticky until reset or an accepted `start`:
  - [0]: `cwr` and `crd` both 1 in the same cycle.
  - [1]: L1 write with `caddr_wr` ≥ `L1_DEPTH`.
  - [2]: `cwr` or `crd` with an invalid `csel`.
  - [3]: `busy`=1 while in IDLE.
- When not defined, `err` is tied to 4'b0 and the checker logic is absent. Dropping behaviour is identical either way.

## Test plan
- Handshake:
  - Stimulus: reset low 2 cycles, then `start` pulse, then `busy`=1 three cycles later, then `busy`=0 after 100 cycles.
  - Required: `ready` high from cycle+1 until one cycle after `busy` rises; a single `done` pulse two cycles after `busy` falls.
- Image path:
  - Stimulus: load image[k]=k^20'h5A5A5 for all k in IDLE, then sweep `iaddr` 0..4095.
  - Required: `idata` matches every word; `img_we` in RUN leaves the image unchanged.
- L0 bank:
  - Stimulus: write 4096 words with `csel`=001, then read back with `crd`.
  - Required: data matches; `l0_cnt`=4096 and stays 4096 after an extra write.
- L1 bound:
  - Stimulus: write `csel`=011 at address 1023 (value 20'hABCDE), then at address 1024.
  - Required: address 1023 reads 20'hABCDE; address 1024 reads 0; `l1_cnt`=1; `err[1]`=1 with `CONV_MEM_CHK_EN`, 0 without.
- Collision and invalid select:
  - Stimulus: `cwr` and `crd` both set to L0 address 5 (old 3, new 9); separately, `cwr` with `csel`=010.
  - Required: the read returns 3 and the next cycle reads 9; the `csel`=010 write is dropped; `err[0]`=1 and `err[2]`=1.
- Reset mid-RUN:
  - Stimulus: assert reset during RUN.
  - Required: outputs reset, no `done` pulse, previous L0 data still readable via `dbg_*`.
